// File: rtl/sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package sub_pkg;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result bus of the serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = sub_pkg::DEFAULT_WIDTH);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             V;

    modport master (output start, A, B, Bin, input busy, done, Diff, Bout, V);
    modport slave  (input start, A, B, Bin, output busy, done, Diff, Bout, V);
endinterface

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: diff = a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first through one registered borrow; results
// land on entry to DONE and hold until the next operation completes.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;
    logic             d_bit;
    logic             b_bit;
    logic [WIDTH-1:0] res_next;

    full_subtractor fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .diff (d_bit),
        .bout (b_bit)
    );

    assign res_next = {d_bit, res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res      <= '0;
            borrow   <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.Diff <= '0;
            bus.Bout <= 1'b0;
            bus.V    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sr     <= bus.A;
                        b_sr     <= bus.B;
                        borrow   <= bus.Bin;
                        cnt      <= '0;
                        a_msb    <= bus.A[WIDTH-1];
                        b_msb    <= bus.B[WIDTH-1];
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res    <= res_next;
                    borrow <= b_bit;
                    cnt    <= cnt + 1'b1;
                    // Last bit: publish results straight from this cycle's
                    // subtractor outputs so they are visible during DONE.
                    if (cnt == LAST) begin
                        bus.Diff <= res_next;
                        bus.Bout <= b_bit;
                        bus.V    <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
